// File: rtl/mock_cu_core.sv
// Mock control unit on a daisy-chained channel: it answers one device address and runs the
// select / command / status / data / ending handshake, and it passes all other traffic down the chain.
module mock_cu_core #(
  parameter logic [7:0] ADDRESS = 8'h10
) (
  input  logic        clk,
  input  logic        reset,
  // outbound bus and tags from the channel
  input  logic [7:0]  b_bus_out,
  input  logic        b_bus_out_parity,
  input  logic        b_operational_out,
  input  logic        b_hold_out,
  input  logic        b_select_out,
  input  logic        b_address_out,
  input  logic        b_command_out,
  input  logic        b_service_out,
  input  logic        b_suppress_out,
  // inbound bus and tags to the channel
  output logic [7:0]  b_bus_in,
  output logic        b_bus_in_parity,
  output logic        b_request_in,
  output logic        b_select_in,
  output logic        b_operational_in,
  output logic        b_address_in,
  output logic        b_status_in,
  output logic        b_service_in,
  // outbound bus and tags passed on to the downstream unit
  output logic [7:0]  a_bus_out,
  output logic        a_bus_out_parity,
  output logic        a_operational_out,
  output logic        a_hold_out,
  output logic        a_select_out,
  output logic        a_address_out,
  output logic        a_command_out,
  output logic        a_service_out,
  output logic        a_suppress_out,
  // inbound bus and tags from the downstream unit
  input  logic [7:0]  a_bus_in,
  input  logic        a_bus_in_parity,
  input  logic        a_request_in,
  input  logic        a_select_in,
  input  logic        a_operational_in,
  input  logic        a_address_in,
  input  logic        a_status_in,
  input  logic        a_service_in,
  // unit model controls and observation
  input  logic        mock_busy,
  input  logic [15:0] mock_limit,
  output logic [7:0]  command,
  output logic [15:0] count
);

  // state    | meaning
  // IDLE     | not selected; select is passed downstream
  // ADDR     | address answered with operational_in/address_in
  // CMD      | command byte latched, waiting for command_out to drop
  // STAT     | initial status presented
  // DATA_REQ | waits for quiet tags, then service_in for one data byte
  // DATA_ACK | byte accepted, waiting for service_out to drop
  // END_STAT | waits for quiet tags, then ending status 8'h0C
  // DISC     | operational_in dropped, waiting for the channel to go quiet
  typedef enum logic [2:0] {
    IDLE, ADDR, CMD, STAT, DATA_REQ, DATA_ACK, END_STAT, DISC
  } state_t;

  state_t      state;
  logic [7:0]  own_bus;
  logic        own_drive;
  logic        own_opl;
  logic        own_adr;
  logic        own_sta;
  logic        own_srv;
  logic        busy_q;
  logic [15:0] limit_q;
  logic        xfer_cmd;
  logic        is_read;

  assign is_read  = (command[1:0] == 2'b10);
  assign xfer_cmd = (command[1:0] == 2'b10) || (command[1:0] == 2'b01);

  // Outbound chaining; select is withheld while this unit owns the interface
  assign a_bus_out         = b_bus_out;
  assign a_bus_out_parity  = b_bus_out_parity;
  assign a_operational_out = b_operational_out;
  assign a_hold_out        = b_hold_out;
  assign a_address_out     = b_address_out;
  assign a_command_out     = b_command_out;
  assign a_service_out     = b_service_out;
  assign a_suppress_out    = b_suppress_out;
  assign a_select_out      = ((state != IDLE) ||
                              (b_address_out && (b_bus_out == ADDRESS))) ? 1'b0 : b_select_out;

  assign b_bus_in         = own_bus | a_bus_in;
  assign b_bus_in_parity  = own_drive ? ~^own_bus : a_bus_in_parity;
  assign b_request_in     = a_request_in;
  assign b_select_in      = a_select_in;
  assign b_operational_in = own_opl | a_operational_in;
  assign b_address_in     = own_adr | a_address_in;
  assign b_status_in      = own_sta | a_status_in;
  assign b_service_in     = own_srv | a_service_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      own_bus   <= 8'h00;
      own_drive <= 1'b0;
      own_opl   <= 1'b0;
      own_adr   <= 1'b0;
      own_sta   <= 1'b0;
      own_srv   <= 1'b0;
      busy_q    <= 1'b0;
      limit_q   <= 16'h0000;
      command   <= 8'h00;
      count     <= 16'h0000;
    end else if (!b_operational_out) begin
      // channel reset: drop everything, keep command/count for inspection
      state     <= IDLE;
      own_bus   <= 8'h00;
      own_drive <= 1'b0;
      own_opl   <= 1'b0;
      own_adr   <= 1'b0;
      own_sta   <= 1'b0;
      own_srv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (b_hold_out && b_select_out && b_address_out && (b_bus_out == ADDRESS)) begin
            state     <= ADDR;
            own_opl   <= 1'b1;
            own_adr   <= 1'b1;
            own_bus   <= ADDRESS;
            own_drive <= 1'b1;
          end
        end
        ADDR: begin
          if (b_command_out && !b_address_out) begin
            state     <= CMD;
            command   <= b_bus_out;
            count     <= 16'h0000;
            busy_q    <= mock_busy;
            limit_q   <= mock_limit;
            own_adr   <= 1'b0;
            own_bus   <= 8'h00;
            own_drive <= 1'b0;
          end
        end
        CMD: begin
          if (!b_command_out) begin
            state     <= STAT;
            own_sta   <= 1'b1;
            own_bus   <= busy_q ? 8'h10 : 8'h00;
            own_drive <= 1'b1;
          end
        end
        STAT: begin
          if (b_service_out || b_command_out) begin
            own_sta   <= 1'b0;
            own_bus   <= 8'h00;
            own_drive <= 1'b0;
            if (busy_q) begin
              state   <= DISC;
              own_opl <= 1'b0;
            end else if (xfer_cmd && (limit_q != 16'h0000)) begin
              state <= DATA_REQ;
            end else begin
              state <= END_STAT;
            end
          end
        end
        DATA_REQ: begin
          if (!own_srv) begin
            if (!b_service_out && !b_command_out) begin
              own_srv <= 1'b1;
              if (is_read) begin
                own_bus   <= count[7:0];
                own_drive <= 1'b1;
              end
            end
          end else if (b_service_out) begin
            own_srv   <= 1'b0;
            own_bus   <= 8'h00;
            own_drive <= 1'b0;
            if (count != 16'hFFFF) count <= count + 16'h0001;
            state     <= DATA_ACK;
          end else if (b_command_out) begin
            own_srv   <= 1'b0;
            own_bus   <= 8'h00;
            own_drive <= 1'b0;
            state     <= END_STAT;
          end
        end
        DATA_ACK: begin
          if (!b_service_out) state <= (count < limit_q) ? DATA_REQ : END_STAT;
        end
        END_STAT: begin
          if (!own_sta) begin
            if (!b_service_out && !b_command_out) begin
              own_sta   <= 1'b1;
              own_bus   <= 8'h0C;
              own_drive <= 1'b1;
            end
          end else if (b_service_out || b_command_out) begin
            own_sta   <= 1'b0;
            own_bus   <= 8'h00;
            own_drive <= 1'b0;
            own_opl   <= 1'b0;
            state     <= DISC;
          end
        end
        DISC: begin
          own_opl <= 1'b0;
          if (!b_service_out && !b_command_out && !b_select_out) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mock_cu_core.sv
// Bench for mock_cu_core: a pass-through vector table, then channel-side sequences whose
// expected in-bound bytes come from a scoreboard queue.
module tb_mock_cu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  b_bus_out;
  logic        b_bus_out_parity, b_operational_out, b_hold_out, b_select_out;
  logic        b_address_out, b_command_out, b_service_out, b_suppress_out;
  logic [7:0]  b_bus_in;
  logic        b_bus_in_parity, b_request_in, b_select_in, b_operational_in;
  logic        b_address_in, b_status_in, b_service_in;
  logic [7:0]  a_bus_out;
  logic        a_bus_out_parity, a_operational_out, a_hold_out, a_select_out;
  logic        a_address_out, a_command_out, a_service_out, a_suppress_out;
  logic [7:0]  a_bus_in;
  logic        a_bus_in_parity, a_request_in, a_select_in, a_operational_in;
  logic        a_address_in, a_status_in, a_service_in;
  logic        mock_busy;
  logic [15:0] mock_limit;
  logic [7:0]  command;
  logic [15:0] count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mock_cu_core #(.ADDRESS(8'h10)) dut (
    .clk(clk), .reset(reset),
    .b_bus_out(b_bus_out), .b_bus_out_parity(b_bus_out_parity),
    .b_operational_out(b_operational_out), .b_hold_out(b_hold_out),
    .b_select_out(b_select_out), .b_address_out(b_address_out),
    .b_command_out(b_command_out), .b_service_out(b_service_out),
    .b_suppress_out(b_suppress_out),
    .b_bus_in(b_bus_in), .b_bus_in_parity(b_bus_in_parity),
    .b_request_in(b_request_in), .b_select_in(b_select_in),
    .b_operational_in(b_operational_in), .b_address_in(b_address_in),
    .b_status_in(b_status_in), .b_service_in(b_service_in),
    .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
    .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
    .a_select_out(a_select_out), .a_address_out(a_address_out),
    .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out),
    .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
    .a_request_in(a_request_in), .a_select_in(a_select_in),
    .a_operational_in(a_operational_in), .a_address_in(a_address_in),
    .a_status_in(a_status_in), .a_service_in(a_service_in),
    .mock_busy(mock_busy), .mock_limit(mock_limit),
    .command(command), .count(count)
  );

  typedef struct {
    logic [7:0] bbus;
    logic [6:0] btags;   // {op, hold, sel, adr, cmd, svc, sup}
    logic [7:0] abus;
    logic       apar;
    logic [5:0] atags;   // {request, select, operational, address, status, service}
    logic       exp_asel;
    logic [7:0] exp_bbus;
    logic       exp_bpar;
    logic [5:0] exp_btags;
  } vec_t;

  typedef struct {
    bit         is_srv;
    logic [7:0] byte_v;
    logic       par;
    bit         stop;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic tag_val(input int which);
    case (which)
      0: return b_status_in;
      1: return b_service_in;
      2: return b_operational_in;
      3: return b_address_in;
      default: return b_status_in | b_service_in;
    endcase
  endfunction

  task automatic wait_tag(input int which, input logic val, input string nm);
    int n = 0;
    while (tag_val(which) !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, tag_val(which)}, {31'd0, val});
  endtask

  task automatic idle_inputs();
    b_bus_out = 8'h00; b_bus_out_parity = 1'b0; b_operational_out = 1'b1;
    b_hold_out = 1'b0; b_select_out = 1'b0; b_address_out = 1'b0;
    b_command_out = 1'b0; b_service_out = 1'b0; b_suppress_out = 1'b0;
    a_bus_in = 8'h00; a_bus_in_parity = 1'b0;
    {a_request_in, a_select_in, a_operational_in, a_address_in, a_status_in, a_service_in} = 6'd0;
  endtask

  task automatic select_dev(input logic [7:0] cmd_byte);
    @(negedge clk);
    b_hold_out = 1'b1; b_select_out = 1'b1; b_address_out = 1'b1; b_bus_out = 8'h10;
    chk("a_select_out blocked on own address", {31'd0, a_select_out}, 32'd0);
    wait_tag(3, 1'b1, "address_in raised");
    chk("address byte echoed", {24'd0, b_bus_in}, 32'h10);
    chk("operational_in at select", {31'd0, b_operational_in}, 32'd1);
    b_address_out = 1'b0; b_command_out = 1'b1; b_bus_out = cmd_byte;
    @(negedge clk);
    b_command_out = 1'b0; b_bus_out = 8'h00;
  endtask

  task automatic run_exchanges(input string nm);
    exp_t e;
    while (sb.size() > 0) begin
      wait_tag(4, 1'b1, {nm, " in-tag raised"});
      e = sb.pop_front();
      chk({nm, " tag kind"}, {30'd0, b_service_in, b_status_in}, {30'd0, e.is_srv, ~e.is_srv});
      chk({nm, " bus_in"}, {24'd0, b_bus_in}, {24'd0, e.byte_v});
      chk({nm, " parity"}, {31'd0, b_bus_in_parity}, {31'd0, e.par});
      if (e.stop) b_command_out = 1'b1;
      else b_service_out = 1'b1;
      @(negedge clk);
      wait_tag(4, 1'b0, {nm, " in-tag dropped"});
      b_command_out = 1'b0; b_service_out = 1'b0;
    end
  endtask

  task automatic finish_sel(input string nm);
    wait_tag(2, 1'b0, {nm, " operational_in dropped"});
    @(negedge clk);
    b_select_out = 1'b0; b_hold_out = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h00, 7'b0000000, 8'h00, 1'b0, 6'b000000, 1'b0, 8'h00, 1'b0, 6'b000000};
    vecs[1] = '{8'h10, 7'b1110000, 8'h00, 1'b0, 6'b000000, 1'b1, 8'h00, 1'b0, 6'b000000};
    vecs[2] = '{8'h10, 7'b1111000, 8'h00, 1'b1, 6'b000000, 1'b0, 8'h00, 1'b1, 6'b000000};
    vecs[3] = '{8'h20, 7'b1111001, 8'h00, 1'b0, 6'b000000, 1'b1, 8'h00, 1'b0, 6'b000000};
    vecs[4] = '{8'hA5, 7'b1000110, 8'h5A, 1'b1, 6'b100010, 1'b0, 8'h5A, 1'b1, 6'b100010};
    vecs[5] = '{8'h3C, 7'b0100101, 8'h81, 1'b0, 6'b011101, 1'b0, 8'h81, 1'b0, 6'b011101};

    idle_inputs();
    mock_busy = 1'b0; mock_limit = 16'd3;
    reset = 1'b1;
    #12;
    chk("reset command", {24'd0, command}, 32'h0);
    chk("reset count", {16'd0, count}, 32'h0);
    chk("reset in-tags", {26'd0, b_request_in, b_select_in, b_operational_in, b_address_in,
        b_status_in, b_service_in}, 32'd0);

    // pass-through paths, exercised while reset holds the FSM in IDLE
    for (int i = 0; i < 6; i++) begin
      b_bus_out = vecs[i].bbus; b_bus_out_parity = ^vecs[i].bbus;
      {b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out,
       b_service_out, b_suppress_out} = vecs[i].btags;
      a_bus_in = vecs[i].abus; a_bus_in_parity = vecs[i].apar;
      {a_request_in, a_select_in, a_operational_in, a_address_in, a_status_in,
       a_service_in} = vecs[i].atags;
      #1;
      chk($sformatf("vec%0d a_select_out", i), {31'd0, a_select_out}, {31'd0, vecs[i].exp_asel});
      chk($sformatf("vec%0d a outbound", i), {15'd0, a_bus_out, a_bus_out_parity, a_operational_out,
          a_hold_out, a_address_out, a_command_out, a_service_out, a_suppress_out},
          {15'd0, vecs[i].bbus, ^vecs[i].bbus, vecs[i].btags[6:5], vecs[i].btags[3:0]});
      chk($sformatf("vec%0d b inbound", i), {17'd0, b_bus_in, b_bus_in_parity, b_request_in,
          b_select_in, b_operational_in, b_address_in, b_status_in, b_service_in},
          {17'd0, vecs[i].exp_bbus, vecs[i].exp_bpar, vecs[i].exp_btags});
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // read, limit 3
    mock_limit = 16'd3; mock_busy = 1'b0;
    sb.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
    sb.push_back('{1'b1, 8'h00, 1'b1, 1'b0});
    sb.push_back('{1'b1, 8'h01, 1'b0, 1'b0});
    sb.push_back('{1'b1, 8'h02, 1'b0, 1'b0});
    sb.push_back('{1'b0, 8'h0C, 1'b1, 1'b0});
    select_dev(8'h02);
    run_exchanges("read");
    finish_sel("read");
    chk("read count", {16'd0, count}, 32'd3);
    chk("read command", {24'd0, command}, 32'h02);

    // busy at initial selection
    mock_busy = 1'b1; mock_limit = 16'd4;
    sb.push_back('{1'b0, 8'h10, 1'b0, 1'b0});
    select_dev(8'h01);
    run_exchanges("busy");
    chk("busy no service_in", {31'd0, b_service_in}, 32'd0);
    finish_sel("busy");
    chk("busy count", {16'd0, count}, 32'd0);
    chk("busy command", {24'd0, command}, 32'h01);
    mock_busy = 1'b0;

    // other address: stays silent, select flows downstream
    @(negedge clk);
    b_hold_out = 1'b1; b_select_out = 1'b1; b_address_out = 1'b1; b_bus_out = 8'h20;
    repeat (3) @(negedge clk);
    chk("addr20 in-tags", {28'd0, b_operational_in, b_address_in, b_status_in, b_service_in}, 32'd0);
    chk("addr20 a_select high", {31'd0, a_select_out}, 32'd1);
    b_select_out = 1'b0;
    #1;
    chk("addr20 a_select low", {31'd0, a_select_out}, 32'd0);
    idle_inputs();
    @(negedge clk);

    // write, limit 5, stop on the second byte
    mock_limit = 16'd5;
    sb.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
    sb.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    sb.push_back('{1'b1, 8'h00, 1'b0, 1'b1});
    sb.push_back('{1'b0, 8'h0C, 1'b1, 1'b0});
    select_dev(8'h01);
    run_exchanges("write-stop");
    finish_sel("write-stop");
    chk("write-stop count", {16'd0, count}, 32'd1);

    // operational_out dropped during DATA_REQ
    mock_limit = 16'd3;
    sb.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
    sb.push_back('{1'b1, 8'h00, 1'b1, 1'b0});
    select_dev(8'h02);
    run_exchanges("opdrop");
    wait_tag(1, 1'b1, "opdrop second service_in");
    b_operational_out = 1'b0;
    @(negedge clk);
    chk("opdrop in-tags", {28'd0, b_operational_in, b_address_in, b_status_in, b_service_in}, 32'd0);
    chk("opdrop bus_in", {24'd0, b_bus_in}, 32'd0);
    chk("opdrop count kept", {16'd0, count}, 32'd1);
    chk("opdrop command kept", {24'd0, command}, 32'h02);
    idle_inputs();
    @(negedge clk);

    // reset in mid-command
    sb.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
    sb.push_back('{1'b1, 8'h00, 1'b1, 1'b0});
    select_dev(8'h02);
    run_exchanges("midreset");
    wait_tag(1, 1'b1, "midreset second service_in");
    #2 reset = 1'b1;
    #1;
    chk("midreset command", {24'd0, command}, 32'h0);
    chk("midreset count", {16'd0, count}, 32'h0);
    chk("midreset in-tags", {28'd0, b_operational_in, b_address_in, b_status_in, b_service_in}, 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
